varredura_tabuleiro: RTL
========================

VARREDURA_TABULEIRO -- requirements
Module: varredura_tabuleiro

Interface
REQ-001 Parameter DWELL, 4: clock cycles each row stays driven; columns are sampled on the last cycle of the dwell.
REQ-002 Parameter ESTAVEL, 3: consecutive identical frames required to confirm a press or a release.
REQ-003 clock  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 habilita  input  1  1 = scanning enabled.
REQ-006 colunas  input  8  column sense lines; bit c=1 means the square at the active row, column c is occupied or pressed.
REQ-007 linhas  output  8  one-hot row drive, active-high.
REQ-008 jogadaFileira  output  4  confirmed row, 1..8 (row index+1).
REQ-009 jogadaColuna  output  4  confirmed column, 1..8 (column index+1, for A..H display).
REQ-010 temJogada  output  1  one-cycle pulse when a new move is confirmed.
REQ-011 multiplo  output  1  1 while the last completed frame saw more than one active square.
REQ-012 db_estado  output  4  current FSM state code.

Function
REQ-013 Scanner: row index r cycles 0..7, each held DWELL cycles; frame = 8*DWELL cycles; linhas = 1<<r while habilita=1, else 0.
REQ-014 Per frame: hit count saturates at 2; coordinate of the single hit is latched (r, c).
REQ-015 Frame end = sample cycle of row 7; the frame result is evaluated and the hit accumulators cleared in that same cycle.
REQ-016 FSM states and codes: OCIOSO=0, ARMADO=1, CONFIRMA=2, EMITE=3, SOLTAR=4.
REQ-017 OCIOSO: when habilita=1 -> ARMADO, with the scan starting at r=0 on the next cycle.
REQ-018 ARMADO at frame end: exactly one hit -> CONFIRMA, candidate=(r,c), count=1; otherwise stay.
REQ-019 CONFIRMA at frame end: same single hit -> count+1; when count reaches ESTAVEL -> EMITE; any other result (zero hits, multiple hits, different square) -> ARMADO, count=0.
REQ-020 EMITE: lasts exactly one cycle; temJogada=1; jogadaFileira/jogadaColuna load candidate+1; -> SOLTAR, count=0.
REQ-021 SOLTAR at frame end: zero hits -> count+1, reaching ESTAVEL -> ARMADO; any hit -> count=0, stay.
REQ-022 jogadaFileira/jogadaColuna hold their value until the next EMITE.
REQ-023 multiplo updates at every frame end and holds between frame ends.
REQ-024 habilita=0 in any state: next cycle -> OCIOSO, r/dwell/count/accumulators cleared, linhas=0, temJogada=0, coordinates held.
REQ-025 Latency: temJogada asserts the cycle after the frame end that brings count to ESTAVEL.
REQ-026 temJogada never asserts twice without an intervening confirmed release.

Reset
REQ-027 reset=0 asynchronously forces: state=OCIOSO, linhas=0, jogadaFileira=0, jogadaColuna=0, temJogada=0, multiplo=0, db_estado=0, all counters 0.
REQ-028 Reset asserted mid-frame or mid-confirmation discards the candidate; no pulse is generated after release of reset until a full new confirmation completes.

Verification (DWELL=4, ESTAVEL=3, frame=32 cycles)
REQ-029 colunas bit 5 high whenever linhas[2]=1, held from frame start -> one temJogada pulse after the 3rd frame end; jogadaFileira=3, jogadaColuna=6.
REQ-030 Square held for 2 frames, then released -> no temJogada; state returns to ARMADO.
REQ-031 Two squares active in the same frame -> multiplo=1 at frame end, no pulse; after removing one, a pulse occurs 3 frames later for the remaining square.
REQ-032 Square held for 10 frames -> exactly one pulse; re-pressing after 3 empty frames -> second pulse.
REQ-033 habilita=0 during CONFIRMA -> linhas=0, db_estado=0 on the next cycle; no pulse.
REQ-034 reset=0 asserted asynchronously between clock edges during SOLTAR -> all outputs 0 immediately.

Source files
------------

// File: rtl/varredura_tabuleiro.sv
// varredura_tabuleiro: chess-board square scanner with press/release debounce.
//
// Drives one row at a time (one-hot, active-high), holding each row for DWELL cycles and
// sampling the column sense lines on the last cycle of the dwell. A frame is eight rows. A move
// is confirmed when exactly one square is seen in ESTAVEL consecutive frames. Then nothing is
// accepted until ESTAVEL consecutive empty frames confirm the release.
//
// Ports:
//   clock_i          system clock, rising edge
//   reset_ni         asynchronous active-low reset
//   habilita_i       1 = scanning enabled; 0 = return to idle next cycle
//   colunas_i[7:0]   column sense lines for the currently driven row
//   linhas_o[7:0]    one-hot row drive
//   jogadaFileira_o  confirmed row 1..8 (held until the next move)
//   jogadaColuna_o   confirmed column 1..8 (held until the next move)
//   temJogada_o      one-cycle pulse on a newly confirmed move
//   multiplo_o       last completed frame saw more than one active square
//   db_estado_o      current FSM state code

module varredura_tabuleiro #(
   parameter int unsigned DWELL   = 4,
   parameter int unsigned ESTAVEL = 3
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic       habilita_i,
   input  logic [7:0] colunas_i,
   output logic [7:0] linhas_o,
   output logic [3:0] jogadaFileira_o,
   output logic [3:0] jogadaColuna_o,
   output logic       temJogada_o,
   output logic       multiplo_o,
   output logic [3:0] db_estado_o
);

   localparam int unsigned DwW  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int unsigned CntW = $clog2(ESTAVEL + 1);

   typedef enum logic [3:0] {
      StOcioso   = 4'd0,
      StArmado   = 4'd1,
      StConfirma = 4'd2,
      StEmite    = 4'd3,
      StSoltar   = 4'd4
   } estado_e;

   estado_e         estado_q;
   logic [2:0]      r_q;
   logic [DwW-1:0]  dwell_q;
   logic [1:0]      hits_q;
   logic [2:0]      hit_r_q, hit_c_q;
   logic [2:0]      cand_r_q, cand_c_q;
   logic [CntW-1:0] cont_q;
   logic [7:0]      linhas_q;
   logic [3:0]      fileira_q, coluna_q;
   logic            tem_q, mult_q;

   logic           amostra, fim_quadro, um_so;
   logic [1:0]     pc, hits_tot;
   logic [2:0]     col_idx, soma;
   logic [2:0]     r_d, hit_r_d, hit_c_d;
   logic [DwW-1:0] dwell_d;

   // Row sample: saturating popcount of the columns plus the index of the (single) hit.
   always_comb begin
      pc      = 2'd0;
      col_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (colunas_i[i]) begin
            col_idx = 3'(i);
            if (pc != 2'd2) pc = pc + 2'd1;
         end
      end
   end

   always_comb begin
      amostra    = (dwell_q == DwW'(DWELL - 1));
      fim_quadro = amostra && (r_q == 3'd7);
      soma       = {1'b0, hits_q} + {1'b0, pc};
      hits_tot   = (soma >= 3'd2) ? 2'd2 : soma[1:0];
      // Only the first hit of a frame is kept; a later one makes the frame a multiple anyway.
      if (amostra && (hits_q == 2'd0) && (pc == 2'd1)) begin
         hit_r_d = r_q;
         hit_c_d = col_idx;
      end else begin
         hit_r_d = hit_r_q;
         hit_c_d = hit_c_q;
      end
      um_so = (hits_tot == 2'd1);
      if (amostra) begin
         dwell_d = '0;
         r_d     = r_q + 3'd1;
      end else begin
         dwell_d = dwell_q + DwW'(1);
         r_d     = r_q;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         estado_q  <= StOcioso;
         r_q       <= '0;
         dwell_q   <= '0;
         hits_q    <= '0;
         hit_r_q   <= '0;
         hit_c_q   <= '0;
         cand_r_q  <= '0;
         cand_c_q  <= '0;
         cont_q    <= '0;
         linhas_q  <= '0;
         fileira_q <= '0;
         coluna_q  <= '0;
         tem_q     <= 1'b0;
         mult_q    <= 1'b0;
      end else if (!habilita_i) begin
         // Coordinates and multiplo are kept; everything in flight is dropped.
         estado_q <= StOcioso;
         r_q      <= '0;
         dwell_q  <= '0;
         hits_q   <= '0;
         hit_r_q  <= '0;
         hit_c_q  <= '0;
         cont_q   <= '0;
         linhas_q <= '0;
         tem_q    <= 1'b0;
      end else begin
         tem_q <= 1'b0;
         if (estado_q == StOcioso) begin
            estado_q <= StArmado;
            r_q      <= '0;
            dwell_q  <= '0;
            hits_q   <= '0;
            linhas_q <= 8'h01;
         end else begin
            r_q      <= r_d;
            dwell_q  <= dwell_d;
            linhas_q <= 8'h01 << r_d;
            if (fim_quadro) begin
               hits_q <= '0;
               mult_q <= (hits_tot == 2'd2);
            end else if (amostra) begin
               hits_q  <= hits_tot;
               hit_r_q <= hit_r_d;
               hit_c_q <= hit_c_d;
            end
            unique case (estado_q)
               StArmado: begin
                  if (fim_quadro && um_so) begin
                     cand_r_q <= hit_r_d;
                     cand_c_q <= hit_c_d;
                     if (ESTAVEL <= 1) begin
                        estado_q  <= StEmite;
                        tem_q     <= 1'b1;
                        fileira_q <= 4'({1'b0, hit_r_d}) + 4'd1;
                        coluna_q  <= 4'({1'b0, hit_c_d}) + 4'd1;
                     end else begin
                        estado_q <= StConfirma;
                        cont_q   <= CntW'(1);
                     end
                  end
               end
               StConfirma: begin
                  if (fim_quadro) begin
                     if (um_so && (hit_r_d == cand_r_q) && (hit_c_d == cand_c_q)) begin
                        cont_q <= cont_q + CntW'(1);
                        if (cont_q == CntW'(ESTAVEL - 1)) begin
                           estado_q  <= StEmite;
                           tem_q     <= 1'b1;
                           fileira_q <= 4'({1'b0, cand_r_q}) + 4'd1;
                           coluna_q  <= 4'({1'b0, cand_c_q}) + 4'd1;
                        end
                     end else begin
                        estado_q <= StArmado;
                        cont_q   <= '0;
                     end
                  end
               end
               StEmite: begin
                  estado_q <= StSoltar;
                  cont_q   <= '0;
               end
               StSoltar: begin
                  if (fim_quadro) begin
                     if (hits_tot == 2'd0) begin
                        if (cont_q == CntW'(ESTAVEL - 1)) begin
                           estado_q <= StArmado;
                           cont_q   <= '0;
                        end else begin
                           cont_q <= cont_q + CntW'(1);
                        end
                     end else begin
                        cont_q <= '0;
                     end
                  end
               end
               default: estado_q <= StOcioso;
            endcase
         end
      end
   end

   assign linhas_o        = linhas_q;
   assign jogadaFileira_o = fileira_q;
   assign jogadaColuna_o  = coluna_q;
   assign temJogada_o     = tem_q;
   assign multiplo_o      = mult_q;
   assign db_estado_o     = estado_q;

endmodule
